// File: rtl/qmux_lock_if.sv
// Valid/ready queue link: producer drives valid/data, consumer drives ready.
interface dti #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/qmux_lock.sv
// Merges NUM_IN queue streams into one {eot, ctrl, data} stream; round-robin
// grant held for a whole transaction so items of different sources never interleave.
module qmux_lock #(
  parameter int W_DATA = 16,
  parameter int LVL    = 1,
  parameter int NUM_IN = 2,
  parameter int W_CTRL = $clog2(NUM_IN)
) (
  input  logic clk,
  input  logic rst,
  dti.consumer din [NUM_IN],
  dti.producer dout
);
  localparam int W_IN  = LVL + W_DATA;
  localparam int W_OUT = LVL + W_CTRL + W_DATA;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                         state, state_nxt;
  logic [W_CTRL-1:0]              rr_ptr, rr_nxt, sel, sel_nxt, grant, cur;
  logic [NUM_IN-1:0]              vld, rdy;
  logic [NUM_IN-1:0][W_IN-1:0]    dat;
  logic [W_IN-1:0]                cur_dat;
  logic                           cur_vld, any_vld, found, load_en, xfer, last;
  logic                           out_valid;
  logic [W_OUT-1:0]               out_data;
  int                             idx;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    assign vld[i]       = din[i].valid;
    assign dat[i]       = din[i].data;
    assign din[i].ready = rdy[i];
  end

  function automatic logic [W_CTRL-1:0] next_idx(input logic [W_CTRL-1:0] p);
    return (p == W_CTRL'(NUM_IN - 1)) ? '0 : p + 1'b1;
  endfunction

  assign load_en    = !out_valid || dout.ready;
  assign dout.valid = out_valid;
  assign dout.data  = out_data;

  // Arbitration and input steering; ready is the only path from dout.ready.
  always_comb begin
    any_vld = |vld;
    grant   = rr_ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!found && vld[idx]) begin
        found = 1'b1;
        grant = W_CTRL'(idx);
      end
    end

    cur     = (state == LOCKED) ? sel : grant;
    cur_vld = 1'b0;
    cur_dat = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (W_CTRL'(i) == cur) begin
        cur_vld = vld[i];
        cur_dat = dat[i];
      end
    end

    for (int i = 0; i < NUM_IN; i++)
      rdy[i] = !rst && load_en && (W_CTRL'(i) == cur) && (state == LOCKED || any_vld);

    xfer = !rst && load_en && cur_vld;
    last = &cur_dat[W_IN-1 -: LVL];
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: if (xfer) begin
        if (!last) begin
          state_nxt = LOCKED;
          sel_nxt   = grant;
        end else begin
          rr_nxt = next_idx(grant);
        end
      end
      LOCKED: if (xfer && last) begin
        state_nxt = IDLE;
        rr_nxt    = next_idx(sel);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Single output stage; a drain and a load in the same cycle replace the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) out_data <= {cur_dat[W_IN-1 -: LVL], cur, cur_dat[W_DATA-1:0]};
    end
  end
endmodule

// File: tb/tb_qmux_lock.sv
// Directed bench for qmux_lock: LVL=1 instance for most scenarios, LVL=2 instance for nested eot.
module tb_qmux_lock;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dti #(.W(17)) din1 [2] ();
  dti #(.W(18)) dout1 ();
  dti #(.W(18)) din2 [2] ();
  dti #(.W(19)) dout2 ();

  logic [1:0]       v1, r1, v2, r2;
  logic [1:0][16:0] d1;
  logic [1:0][17:0] d2;
  logic             dready1, dready2;

  for (genvar i = 0; i < 2; i++) begin : g_src
    assign din1[i].valid = v1[i];
    assign din1[i].data  = d1[i];
    assign r1[i]         = din1[i].ready;
    assign din2[i].valid = v2[i];
    assign din2[i].data  = d2[i];
    assign r2[i]         = din2[i].ready;
  end
  assign dout1.ready = dready1;
  assign dout2.ready = dready2;

  qmux_lock #(.W_DATA(16), .LVL(1), .NUM_IN(2)) u_dut1 (
    .clk(clk), .rst(rst), .din(din1), .dout(dout1));
  qmux_lock #(.W_DATA(16), .LVL(2), .NUM_IN(2)) u_dut2 (
    .clk(clk), .rst(rst), .din(din2), .dout(dout2));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [16:0] q10[$], q11[$];
  logic [17:0] q20[$], q21[$];
  logic [17:0] got1[$];
  logic [18:0] got2[$];
  int          gc2[$];

  logic [1:0]  s_r1;
  logic        s_ov1, s_st1, s_rr1;
  logic [17:0] s_od1;

  task automatic load();
    v1[0] = q10.size() != 0;  d1[0] = v1[0] ? q10[0] : '0;
    v1[1] = q11.size() != 0;  d1[1] = v1[1] ? q11[0] : '0;
    v2[0] = q20.size() != 0;  d2[0] = v2[0] ? q20[0] : '0;
    v2[1] = q21.size() != 0;  d2[1] = v2[1] ? q21[0] : '0;
  endtask

  // Observe one cycle at the falling edge, then retire fired source items after the rising edge.
  task automatic step();
    logic [1:0] f1, f2;
    @(negedge clk);
    s_r1  = r1;
    s_ov1 = dout1.valid;
    s_od1 = dout1.data;
    s_st1 = u_dut1.state;
    s_rr1 = u_dut1.rr_ptr;
    if (!rst && dout1.valid && dready1) got1.push_back(dout1.data);
    if (!rst && dout2.valid && dready2) begin
      got2.push_back(dout2.data);
      gc2.push_back(cyc);
    end
    f1 = v1 & r1;
    f2 = v2 & r2;
    @(posedge clk); #1;
    if (f1[0]) void'(q10.pop_front());
    if (f1[1]) void'(q11.pop_front());
    if (f2[0]) void'(q20.pop_front());
    if (f2[1]) void'(q21.pop_front());
    load();
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; v1 = 2'b11; d1[0] = 17'h10001; d1[1] = 17'h10002;
    v2 = 2'b00; d2 = '0; dready1 = 1'b1; dready2 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (dout1.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dout1.valid); end
    checks++; if (dout1.data !== 18'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", dout1.data); end
    checks++; if (r1 !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", r1); end
    checks++; if (u_dut1.rr_ptr !== 1'b0) begin failures++; $display("FAIL reset_rr got=%b exp=0", u_dut1.rr_ptr); end
    checks++; if (dout2.valid !== 1'b0) begin failures++; $display("FAIL reset_valid2 got=%b exp=0", dout2.valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    load();
  endtask

  task automatic test_basic();
    logic [17:0] ew [4] = '{18'h00011, 18'h00012, 18'h20013, 18'h30021};
    logic        ev;
    got1.delete();
    q10.push_back(17'h00011); q10.push_back(17'h00012); q10.push_back(17'h10013);
    q11.push_back(17'h10021);
    load();
    for (int c = 0; c < 6; c++) begin
      step();
      ev = (c >= 1 && c <= 4);
      checks++; if (s_ov1 !== ev) begin failures++; $display("FAIL basic_valid c=%0d got=%b exp=%b", c, s_ov1, ev); end
      if (ev) begin
        checks++; if (s_od1 !== ew[c-1]) begin failures++; $display("FAIL basic_data c=%0d got=%h exp=%h", c, s_od1, ew[c-1]); end
      end
      if (c <= 3) begin
        checks++; if (s_r1[1] !== (c == 3)) begin failures++; $display("FAIL basic_ready1 c=%0d got=%b exp=%b", c, s_r1[1], c == 3); end
      end
    end
  endtask

  task automatic test_fairness();
    logic [17:0] ex;
    got1.delete();
    for (int k = 0; k < 4; k++) begin
      q10.push_back(17'h100A0 + 17'(k));
      q11.push_back(17'h100B0 + 17'(k));
    end
    load();
    for (int n = 0; n < 30 && got1.size() < 8; n++) step();
    checks++; if (got1.size() != 8) begin failures++; $display("FAIL fair_count got=%0d exp=8", got1.size()); end
    for (int k = 0; k < 8 && k < got1.size(); k++) begin
      ex = (k % 2 == 0) ? 18'h200A0 + 18'(k / 2) : 18'h300B0 + 18'(k / 2);
      checks++; if (got1[k] !== ex) begin failures++; $display("FAIL fair_word k=%0d got=%h exp=%h", k, got1[k], ex); end
    end
    checks++; if (u_dut1.rr_ptr !== 1'b0) begin failures++; $display("FAIL fair_rr got=%b exp=0", u_dut1.rr_ptr); end
  endtask

  task automatic test_backpressure();
    logic [17:0] ew [6] = '{18'h00031, 18'h00032, 18'h00033, 18'h00034, 18'h20035, 18'h3003F};
    got1.delete();
    for (int k = 1; k <= 4; k++) q10.push_back(17'h00030 + 17'(k));
    q10.push_back(17'h10035);
    q11.push_back(17'h1003F);
    load();
    step(); step();
    dready1 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (s_ov1 !== 1'b1 || s_od1 !== 18'h00032) begin failures++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/00032", c, s_ov1, s_od1); end
      checks++; if (s_r1 !== 2'b00) begin failures++; $display("FAIL bp_ready c=%0d got=%b exp=00", c, s_r1); end
    end
    dready1 = 1'b1;
    repeat (4) step();
    checks++; if (got1.size() != 5) begin failures++; $display("FAIL bp_rate got=%0d exp=5", got1.size()); end
    repeat (2) step();
    checks++; if (got1.size() != 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", got1.size()); end
    for (int k = 0; k < 6 && k < got1.size(); k++) begin
      checks++; if (got1[k] !== ew[k]) begin failures++; $display("FAIL bp_word k=%0d got=%h exp=%h", k, got1[k], ew[k]); end
    end
  endtask

  task automatic test_lvl2();
    logic [18:0] ew [4] = '{19'h30051, 19'h30052, 19'h70053, 19'h60041};
    got2.delete(); gc2.delete();
    q20.push_back(18'h30040);
    load();
    for (int n = 0; n < 5 && got2.size() < 1; n++) step();
    checks++; if (got2.size() != 1 || got2[0] !== 19'h60040) begin failures++; $display("FAIL l2_prime got=%0d items exp=1 item 60040", got2.size()); end
    got2.delete(); gc2.delete();
    q21.push_back(18'h10051); q21.push_back(18'h10052); q21.push_back(18'h30053);
    q20.push_back(18'h30041);
    load();
    for (int n = 0; n < 12 && got2.size() < 4; n++) step();
    checks++; if (got2.size() != 4) begin failures++; $display("FAIL l2_count got=%0d exp=4", got2.size()); end
    for (int k = 0; k < 4 && k < got2.size(); k++) begin
      checks++; if (got2[k] !== ew[k]) begin failures++; $display("FAIL l2_word k=%0d got=%h exp=%h", k, got2[k], ew[k]); end
      if (k > 0) begin
        checks++; if (gc2[k] != gc2[k-1] + 1) begin failures++; $display("FAIL l2_contig k=%0d got=%0d exp=%0d", k, gc2[k], gc2[k-1] + 1); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] ew [3] = '{18'h20060, 18'h00061, 18'h30071};
    got1.delete();
    q10.push_back(17'h10060);
    load();
    for (int n = 0; n < 5 && got1.size() < 1; n++) step();
    for (int k = 1; k <= 3; k++) q10.push_back(17'h00060 + 17'(k));
    q10.push_back(17'h10064);
    load();
    step(); step();
    checks++; if (u_dut1.state !== 1'b1) begin failures++; $display("FAIL rm_locked got=%b exp=1", u_dut1.state); end
    rst = 1'b1;
    q10.delete();
    load();
    step();
    checks++; if (s_r1 !== 2'b00) begin failures++; $display("FAIL rm_ready_rst got=%b exp=00", s_r1); end
    rst = 1'b0;
    q11.push_back(17'h10071);
    load();
    step();
    checks++; if (s_ov1 !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", s_ov1); end
    checks++; if (s_st1 !== 1'b0) begin failures++; $display("FAIL rm_state got=%b exp=0", s_st1); end
    checks++; if (s_rr1 !== 1'b0) begin failures++; $display("FAIL rm_rr got=%b exp=0", s_rr1); end
    checks++; if (s_r1 !== 2'b10) begin failures++; $display("FAIL rm_grant got=%b exp=10", s_r1); end
    step();
    checks++; if (s_ov1 !== 1'b1 || s_od1 !== 18'h30071) begin failures++; $display("FAIL rm_out got=%b/%h exp=1/30071", s_ov1, s_od1); end
    step();
    checks++; if (got1.size() != 3) begin failures++; $display("FAIL rm_count got=%0d exp=3", got1.size()); end
    for (int k = 0; k < 3 && k < got1.size(); k++) begin
      checks++; if (got1[k] !== ew[k]) begin failures++; $display("FAIL rm_word k=%0d got=%h exp=%h", k, got1[k], ew[k]); end
    end
  endtask

  task automatic test_random();
    logic [16:0] e0[$], e1[$];
    logic [16:0] it, ex;
    int          lens0 [3] = '{1, 3, 2};
    int          lens1 [3] = '{2, 1, 4};
    int          seq_bad = 0, inter_bad = 0, hold_bad = 0, lock_c = -1, ctrl;
    logic        pv = 1'b0, pr = 1'b1;
    logic [17:0] pd = '0;
    got1.delete();
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < lens0[t]; k++) begin
        it = {k == lens0[t] - 1, 16'h0100 + 16'(t * 16 + k)};
        q10.push_back(it); e0.push_back(it);
      end
      for (int k = 0; k < lens1[t]; k++) begin
        it = {k == lens1[t] - 1, 16'h0200 + 16'(t * 16 + k)};
        q11.push_back(it); e1.push_back(it);
      end
    end
    load();
    for (int n = 0; n < 300 && got1.size() < 13; n++) begin
      dready1 = 1'($urandom_range(0, 1));
      step();
      if (pv && !pr && !(s_ov1 && s_od1 == pd)) hold_bad++;
      pv = s_ov1; pd = s_od1; pr = dready1;
    end
    dready1 = 1'b1;
    checks++; if (got1.size() != 13) begin failures++; $display("FAIL rnd_count got=%0d exp=13", got1.size()); end
    foreach (got1[k]) begin
      ctrl = int'(got1[k][16]);
      it   = {got1[k][17], got1[k][15:0]};
      if (lock_c != -1 && ctrl != lock_c) inter_bad++;
      lock_c = got1[k][17] ? -1 : ctrl;
      if (ctrl == 0) begin
        if (e0.size() == 0) seq_bad++; else begin ex = e0.pop_front(); if (ex !== it) seq_bad++; end
      end else begin
        if (e1.size() == 0) seq_bad++; else begin ex = e1.pop_front(); if (ex !== it) seq_bad++; end
      end
    end
    checks++; if (seq_bad != 0) begin failures++; $display("FAIL rnd_order got=%0d bad exp=0", seq_bad); end
    checks++; if (inter_bad != 0) begin failures++; $display("FAIL rnd_interleave got=%0d exp=0", inter_bad); end
    checks++; if (hold_bad != 0) begin failures++; $display("FAIL rnd_hold got=%0d exp=0", hold_bad); end
    checks++; if (e0.size() + e1.size() != 0) begin failures++; $display("FAIL rnd_missing got=%0d exp=0", e0.size() + e1.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fairness();
    test_backpressure();
    test_lvl2();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qmux_lock.md
Name: qmux_lock

Overview:
- Upstream feeder for the queue field filter stage.
- Merges NUM_IN independent queue streams into one union-tagged queue stream.
- Output word is {eot, ctrl, data}; ctrl is the index of the source input, in the layout the filter stage consumes.
- Round-robin arbitration at transaction granularity: once an input is granted, it owns the output until its top-level eot item transfers, so transactions never interleave.

Parameters:
- W_DATA, 16, width of the data field of each input item.
- LVL, 1, number of eot bits per item; must be >= 1.
- NUM_IN, 2, number of input queues; must be >= 2.
- W_CTRL, $clog2(NUM_IN), width of the ctrl tag in the output word.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- din[NUM_IN]  dti.consumer  LVL+W_DATA  input queues; data = {eot[LVL-1:0], data[W_DATA-1:0]}.
- dout  dti.producer  LVL+W_CTRL+W_DATA  merged queue; data = {eot, ctrl, data}.

Behaviour:
- Reset state: dout.valid=0, dout.data=0, state=IDLE, rr_ptr=0, all din[i].ready=0.
- Handshake: standard dti. A transfer occurs when valid && ready. Inputs hold valid and data until ready; the block holds dout valid and data until dout.ready.
- Output register: one stage, 1-cycle latency, full throughput.
  - load_en = !out_valid || dout handshake.
  - A load and a dout handshake in the same cycle are legal; the new item replaces the old one with no bubble.
- State IDLE:
  - Grant goes to the first valid input searching rr_ptr, rr_ptr+1, ... modulo NUM_IN.
  - din[grant].ready = load_en; every other ready = 0.
  - The item is captured only if load_en. If load_en=0, nothing is committed and arbitration repeats next cycle, so a newly valid higher-priority input may win.
  - On transfer of an item with &eot[LVL-1:0]=0: go to LOCKED, sel=grant.
  - On transfer of an item with all eot bits set (single-item transaction): stay IDLE, rr_ptr = grant+1 mod NUM_IN.
- State LOCKED(sel):
  - din[sel].ready = load_en; all other readys = 0, whatever their valid.
  - On transfer of an item with &eot=1: return to IDLE, rr_ptr = sel+1 mod NUM_IN.
  - Non-top eot bits (e.g. eot[0] with eot[1]=0 when LVL=2) pass through and do not unlock.
- Output word on load: dout.eot = din.eot, dout.ctrl = granted index (zero-extended to W_CTRL), dout.data = din.data.
- When the register is not loading and not draining, contents are held unchanged.
- No combinational path from dout.ready to dout.valid or dout.data. din.ready depends combinationally on dout.ready through load_en.
- Reset mid-transaction: lock dropped, buffered item discarded, rr_ptr=0. Upstream sources are reset in the same cycle.
- Idle: no valid inputs leaves state and rr_ptr unchanged.

Test Plan:
- NUM_IN=2, LVL=1, dout.ready=1. din0 sends [0x11,0x12,0x13(eot)] and din1 sends [0x21(eot)], both valid at cycle 0.
  - Required dout sequence: {0,0,0x11}, {0,0,0x12}, {1,0,0x13}, {1,1,0x21}.
  - Valid from cycle 1, back-to-back with no bubbles; din1.ready=0 until cycle 3.
- Fairness: both inputs continuously send 1-item transactions (eot=1).
  - Required ctrl sequence on dout: 0,1,0,1,... ; rr_ptr alternates.
- Backpressure: dout.ready=0 for 3 cycles in the middle of a din0 transaction.
  - dout holds the same word; din0.ready=0 during the stall.
  - On release, throughput resumes at 1/cycle with no lost or duplicated items.
- LVL=2: din1 sends items with eot=01, 01, 11 while din0 is valid throughout.
  - All three din1 items are output contiguously with ctrl=1 and unchanged eot.
  - The lock releases only after the eot=11 item; din0's item follows immediately.
- Reset at cycle 2 of a 4-item din0 transaction.
  - Next cycle: dout.valid=0, state=IDLE, rr_ptr=0.
  - A subsequent din1-only transaction is granted immediately with ctrl=1.
- Same-cycle drain and load at sustained rate with random dout.ready (50%).
  - The scoreboard matches the per-input ordered item streams and finds no interleaving inside any transaction.
